risci_lsu: RTL

//  Core-side load/store unit: the initiator end of the RAM data port (daddr/dout/din/dlen/re/we).

---
 rtl/risci_pkg.sv | 29 ++
 rtl/risci_lsu_align.sv | 41 ++++
 rtl/risci_lsu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/risci_pkg.sv
// Shared types for the RISC-I load/store unit: access sizes, FSM states and
// the alignment rule used when a request is accepted.
package risci_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    DLEN_B = 2'd0,
    DLEN_H = 2'd1,
    DLEN_W = 2'd2
  } dlen_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

  // Bytes are never misaligned; size 3 is reported as illegal elsewhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'd1:    return addr_lo[0];
      2'd2:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/risci_lsu_align.sv
// Combinational data steering for the LSU: load extension from the assembly
// register, store data trimmed to the access size, and per-beat byte lanes.
module risci_lsu_align
  import risci_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      size,
  input  logic            sgn,
  input  logic [XLEN-1:0] raw,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      beat,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wsized,
  output logic [7:0]      lane
);

  always_comb begin
    rdata  = '0;
    wsized = '0;
    case (size)
      DLEN_B: begin
        rdata  = {{(XLEN-8){sgn & raw[7]}}, raw[7:0]};
        wsized = {{(XLEN-8){1'b0}}, wdata[7:0]};
      end
      DLEN_H: begin
        rdata  = {{(XLEN-16){sgn & raw[15]}}, raw[15:0]};
        wsized = {{(XLEN-16){1'b0}}, wdata[15:0]};
      end
      DLEN_W: begin
        rdata  = raw;
        wsized = wdata;
      end
      default: ;
    endcase
  end

  // Little-endian: beat k carries bits [8k+7:8k].
  assign lane = wdata[{beat, 3'b000} +: 8];

endmodule

// File: rtl/risci_lsu.sv
// Load/store unit: accepts one request, runs aligned or byte-split RAM beats,
// and returns a single extended response held until accepted.
module risci_lsu
  import risci_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEFAULT,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] daddr,
  output logic [XLEN-1:0]   dout,
  output logic [1:0]        dlen,
  output logic              re,
  output logic              we,
  input  logic [XLEN-1:0]   din
);

  lsu_state_t        state, state_nxt;
  logic              r_we, r_sgn, r_err, r_split;
  logic [1:0]        r_size, beat, last_beat;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata, asm_q, ext_rdata, wsized;
  logic [7:0]        lane;
  logic              accept, req_illegal, req_misal, req_err;

  assign accept      = req_valid && (state == LSU_IDLE);
  assign req_illegal = (req_size == 2'd3);
  assign req_misal   = is_misaligned(req_size, req_addr[1:0]);
  assign req_err     = req_illegal || (req_misal && !MISALIGN_SPLIT);

  risci_lsu_align #(.XLEN(XLEN)) u_align (
    .size   (r_size),
    .sgn    (r_sgn),
    .raw    (asm_q),
    .wdata  (r_wdata),
    .beat   (beat),
    .rdata  (ext_rdata),
    .wsized (wsized),
    .lane   (lane)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= LSU_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE:  if (accept) state_nxt = req_err ? LSU_RESP : LSU_ISSUE;
      LSU_ISSUE: state_nxt = LSU_WAIT;
      LSU_WAIT:  state_nxt = (beat != last_beat) ? LSU_ISSUE : LSU_RESP;
      LSU_RESP:  if (resp_ready) state_nxt = LSU_IDLE;
      default:   state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we      <= 1'b0;
      r_sgn     <= 1'b0;
      r_err     <= 1'b0;
      r_split   <= 1'b0;
      r_size    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      beat      <= '0;
      last_beat <= '0;
      asm_q     <= '0;
    end else if (accept) begin
      r_we      <= req_we;
      r_sgn     <= req_signed;
      r_err     <= req_err;
      r_split   <= req_misal;
      r_size    <= req_size;
      r_addr    <= req_addr;
      r_wdata   <= req_wdata;
      beat      <= '0;
      asm_q     <= '0;
      // Split accesses run 2^size byte beats; the counter stores the last index.
      if (req_misal) last_beat <= (req_size == DLEN_H) ? 2'd1 : 2'd3;
      else           last_beat <= 2'd0;
    end else if (state == LSU_WAIT) begin
      if (!r_we) begin
        if (r_split) asm_q[{beat, 3'b000} +: 8] <= din[7:0];
        else         asm_q <= din;
      end
      if (beat != last_beat) beat <= beat + 2'd1;
    end
  end

  always_comb begin
    req_ready  = (state == LSU_IDLE);
    resp_valid = (state == LSU_RESP);
    resp_err   = 1'b0;
    resp_rdata = '0;
    re         = 1'b0;
    we         = 1'b0;
    daddr      = '0;
    dout       = '0;
    dlen       = DLEN_B;
    case (state)
      LSU_ISSUE: begin
        re = !r_we;
        we = r_we;
        if (r_split) begin
          daddr = r_addr + ADDR_W'(beat);
          dlen  = DLEN_B;
          if (r_we) dout = {{(XLEN-8){1'b0}}, lane};
        end else begin
          daddr = r_addr;
          dlen  = r_size;
          if (r_we) dout = wsized;
        end
      end
      LSU_RESP: begin
        resp_err = r_err;
        if (!r_we && !r_err) resp_rdata = ext_rdata;
      end
      default: ;
    endcase
  end

endmodule
